operand_collector: RTL
======================

# operand_collector

Parametrised successor to the three-slot put/done collector. Captures a stream of WIDTH-bit values, presented one per cycle on `put`, into DEPTH slots. It publishes a completed frame to registered outputs with a done/take handshake. Collection into a second internal buffer continues while a published frame waits, so a frame is never torn. Sits between an operand source (decoder or serial loader) and the datapath stage that consumes multi-operand groups.

## Interface
- WIDTH, 8, bits per value/slot
- DEPTH, 3, slots per frame (≥1)
- OVERWRITE_LAST, 1, full-buffer put policy: 1 = overwrite last slot, 0 = drop value and flag overflow
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; clears all state
- put  in  1  write `value` into the collection buffer this cycle
- value  in  WIDTH  data written on `put`
- flush  in  1  publish a partial frame (≥1 slot filled)
- take  in  1  consumer acknowledges the published frame
- slots  out  DEPTH*WIDTH  published frame; slot i at bits [i*WIDTH +: WIDTH]; unfilled slots read 0
- frame_count  out  $clog2(DEPTH+1)  valid slots in the published frame
- frame_overflow  out  1  published frame dropped ≥1 value (OVERWRITE_LAST=0 only)
- fill_count  out  $clog2(DEPTH+1)  current collection-buffer occupancy
- done  out  1  published frame is valid; held until taken

## Operation
- Two buffers: collection buffer `buf[0..DEPTH-1]` with `fill_count` and a sticky `ovf` bit; output registers `slots`/`frame_count`/`frame_overflow`/`done`.
- Put, fill_count < DEPTH: buf[fill_count] ← value; fill_count+1.
- Put, fill_count == DEPTH:
  - OVERWRITE_LAST=1: buf[DEPTH-1] ← value.
  - OVERWRITE_LAST=0: value discarded; ovf ← 1.
- Publish request (req), evaluated on the post-put buffer state:
  - (fill_count == DEPTH && !put), or
  - (flush && post-put fill_count > 0).
- Publish occurs when req && (!done || take):
  - slots ← buf, filled slots only; unfilled slots → 0.
  - frame_count ← post-put fill; frame_overflow ← post-put ovf; done ← 1.
  - buf, fill_count and ovf cleared to 0.
- take && done with no publish that cycle: done ← 0. slots/frame_count hold stale values; they are not cleared.
- req while done && !take: publish stalls, buf holds, and put follows the full rules above. Flush stays pending only while asserted.
- A full buffer with put held high never publishes. The put-low cycle completes the frame.
- Flush with fill_count == 0 and no put: no effect.
- take while !done: ignored.
- Reset: buf, fill_count, ovf, slots, frame_count, frame_overflow and done all 0. Reset overrides put/flush/take in the same cycle. A mid-frame reset discards the partial frame; it is never published.

## Timing
- Put at edge k: fill_count updates after edge k.
- Last put of a full frame at edge k with put=0 at edge k+1: done=1 after edge k+1. Minimum one cycle from frame full to done.
- Flush at edge k with no stall: done=1 after edge k. Same-cycle put value is included.
- take at edge k: done=0 after edge k, unless a publish also happens at edge k. In that case done stays 1 and slots carry the new frame, giving back-to-back frames with no bubble.
- Throughput: one frame per DEPTH+1 cycles with continuous put/idle pattern, or per DEPTH cycles using flush on the last put.
- All outputs registered; no combinational input→output paths.

## Test plan
- Basic, defaults: reset, then put 0x11, 0x22, 0x33 on consecutive cycles, put=0 → done=1 one cycle later, slots={0x33,0x22,0x11}, frame_count=3, frame_overflow=0, fill_count=0. take → done=0 next cycle.
- Flush partial: put 0xA5 with flush same cycle → done=1 after that edge, slot0=0xA5, slots1..2=0, frame_count=1. Flush with empty buffer → no change.
- Full policy: put 0x01, 0x02, 0x03, 0x04 back-to-back, then idle → OVERWRITE_LAST=1: slot2=0x04, frame_overflow=0. OVERWRITE_LAST=0: slot2=0x03, frame_overflow=1.
- Stall/double buffer: frame {1,2,3} published, take held 0, put 4, 5, 6 → done stays 1, slots unchanged, fill_count=3. Assert take → next cycle slots={6,5,4}, done stays 1, fill_count=0.
- Reset mid-frame: put 0x10, 0x20, then reset for 1 cycle, then put 0x30 + flush → frame_count=1, slot0=0x30. Also check every output is 0 immediately after reset.
- Parameter sweep: WIDTH=16, DEPTH=1 and DEPTH=5. Each single put (DEPTH=1) or 5 puts publish correctly; fill_count never exceeds DEPTH.

Source files
------------

// File: rtl/operand_collector.sv
// operand_collector: gathers a stream of values into DEPTH-slot frames and
// publishes each completed frame through a done/take handshake, double-buffered.
`default_nettype none

module operand_collector #(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 3,
  parameter bit OVERWRITE_LAST = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         put,
  input  logic [WIDTH-1:0]             value,
  input  logic                         flush,
  input  logic                         take,
  output logic [DEPTH*WIDTH-1:0]       slots,
  output logic [$clog2(DEPTH+1)-1:0]   frame_count,
  output logic                         frame_overflow,
  output logic [$clog2(DEPTH+1)-1:0]   fill_count,
  output logic                         done
);

  localparam int            CW   = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] coll;
  logic [DEPTH-1:0][WIDTH-1:0] nxt_coll;
  logic [DEPTH-1:0][WIDTH-1:0] pub_slots;
  logic [CW-1:0]               nxt_fill;
  logic                        ovf;
  logic                        nxt_ovf;
  logic                        req;
  logic                        publish;

  // Post-put view of the collection buffer; both publish and hold paths use it.
  always_comb begin
    nxt_coll = coll;
    nxt_fill = fill_count;
    nxt_ovf  = ovf;
    if (put) begin
      if (fill_count != FULL) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == fill_count) nxt_coll[i] = value;
        end
        nxt_fill = fill_count + CW'(1);
      end else if (OVERWRITE_LAST) begin
        nxt_coll[DEPTH-1] = value;
      end else begin
        nxt_ovf = 1'b1;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      pub_slots[i] = (CW'(i) < nxt_fill) ? nxt_coll[i] : '0;
    end
  end

  // A full buffer only completes on a put-low cycle so a held put never tears a frame.
  assign req     = ((fill_count == FULL) && !put) || (flush && (nxt_fill != '0));
  assign publish = req && (!done || take);

  always_ff @(posedge clk) begin
    if (reset) begin
      coll           <= '0;
      fill_count     <= '0;
      ovf            <= 1'b0;
      slots          <= '0;
      frame_count    <= '0;
      frame_overflow <= 1'b0;
      done           <= 1'b0;
    end else if (publish) begin
      slots          <= pub_slots;
      frame_count    <= nxt_fill;
      frame_overflow <= nxt_ovf;
      done           <= 1'b1;
      coll           <= '0;
      fill_count     <= '0;
      ovf            <= 1'b0;
    end else begin
      coll       <= nxt_coll;
      fill_count <= nxt_fill;
      ovf        <= nxt_ovf;
      if (take && done) done <= 1'b0;
    end
  end

endmodule

`default_nettype wire
